scr1_mem_arb: RTL and testbench
===============================

# scr1_mem_arb

Two-requester arbiter sharing one core-side memory port of the AXI memory bridge between the instruction-fetch (IMEM) and load/store (DMEM) interfaces. Selects one request per cycle, forwards it combinationally, records the issuing port in an in-order ID FIFO, and steers each bridge response back to its owner. Sits between the core's memory interfaces and a single bridge instance in the top level.

## Interface
- SCR1_ARB_OUTSTD, 4: max outstanding requests; power of 2, ≥2.
- SCR1_ADDR_WIDTH, 32: address width.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- imem_req  in  1  fetch request; always read, word width.
- imem_req_ack  out  1  fetch request accepted.
- imem_addr  in  SCR1_ADDR_WIDTH  fetch address.
- imem_rdata  out  32  fetch data.
- imem_resp  out  type_scr1_mem_resp_e  fetch response.
- dmem_req  in  1  data request.
- dmem_req_ack  out  1  data request accepted.
- dmem_cmd  in  type_scr1_mem_cmd_e  RD/WR.
- dmem_width  in  type_scr1_mem_width_e  byte/hword/word.
- dmem_addr  in  SCR1_ADDR_WIDTH  data address.
- dmem_wdata  in  32  write data.
- dmem_rdata  out  32  load data.
- dmem_resp  out  type_scr1_mem_resp_e  data response.
- mem_req, mem_cmd, mem_width, mem_addr, mem_wdata  out  1/enum/enum/SCR1_ADDR_WIDTH/32  request to bridge.
- mem_req_ack  in  1  bridge accepted request.
- mem_rdata  in  32  bridge read data.
- mem_resp  in  type_scr1_mem_resp_e  bridge response.
- arb_idle  out  1  no outstanding requests.

## Operation
- Grant: one of IMEM/DMEM drives mem_* each cycle. IMEM requests drive mem_cmd=RD, mem_width=WORD.
- Grant lock: if the granted port has req high and the handshake does not complete, the grant is held next cycle regardless of the other port (no address switching mid-handshake). Lock clears on accept.
- Accept = mem_req & mem_req_ack & ~fifo_full; only the granted port's ack is asserted, and only when accept holds. mem_req = granted req & ~fifo_full.
- On accept, push the granted port ID into the ID FIFO (depth SCR1_ARB_OUTSTD, pointer wrap modulo depth, count 0..SCR1_ARB_OUTSTD).
- On mem_resp ≠ NOTRDY with FIFO non-empty: pop head; head port gets mem_resp and mem_rdata; other port gets NOTRDY, rdata 0.
- Response with FIFO empty: dropped, both ports NOTRDY; simulation assertion fires.
- Full: no accept even if a pop occurs in the same cycle (decided; simple timing). Empty with simultaneous push/pop: push occurs, pop ignored per rule above.
- arb_idle = (count == 0).

## Timing
- Request path combinational: requester req -> mem_req and mem_req_ack -> requester ack, 0 cycles.
- Response path combinational: mem_resp/mem_rdata -> port resp/rdata, 0 cycles; FIFO head updates next edge.
- Reset (synchronous, on rst high at clk edge): count, pointers, lock and round-robin state cleared; outputs: acks 0, resps NOTRDY, rdata 0, mem_req 0, arb_idle 1. Reset mid-transaction discards outstanding IDs; bridge must be reset/reinitialised in the same window.

## Configuration
- SCR1_ARB_RR_EN defined: round-robin; when both request and no lock, grant the port not granted on the last accept (initial: DMEM).
- Undefined: fixed priority, DMEM always wins when both request and no lock. Lock behaviour identical in both.

## Structure
- Shared package: type_scr1_arb_port_e (SCR1_ARB_PORT_IMEM=0, SCR1_ARB_PORT_DMEM=1); memory enums come from existing memif definitions.
- One sub-module: scr1_arb_id_fifo (push/pop/full/empty/head, parameterised depth, synchronous active-high reset).

## Test plan
- IMEM alone, addr 0x100, ack same cycle, resp RDY_OK rdata 0xDEADBEEF two cycles later -> imem_resp RDY_OK, imem_rdata 0xDEADBEEF, dmem_resp NOTRDY.
- Both request continuously, ack every cycle -> with SCR1_ARB_RR_EN grants alternate D,I,D,I; without it, DMEM granted every cycle.
- IMEM granted, mem_req_ack low 3 cycles, DMEM asserts cycle 1 -> mem_addr stays IMEM address until accepted, then DMEM.
- Issue 4 accepts with no responses -> 5th request not acked, arb_idle 0; one response then next request accepted on following cycle.
- Interleaved D-WR, I-RD, D-RD accepted, responses ER, OK, OK -> dmem_resp ER, imem_resp OK, dmem_resp OK, in order.
- Reset asserted with 2 outstanding -> next cycle arb_idle 1, all resps NOTRDY, next request accepted with FIFO empty.

Source files
------------

// File: rtl/scr1_mem_arb_pkg.sv
// Shared types for the IMEM/DMEM memory arbiter: memory interface enums and arbiter port IDs.
package scr1_mem_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_ARB_PORT_IMEM = 1'b0,
    SCR1_ARB_PORT_DMEM = 1'b1
  } type_scr1_arb_port_e;

  function automatic type_scr1_arb_port_e arb_port_other(input type_scr1_arb_port_e p);
    return (p == SCR1_ARB_PORT_IMEM) ? SCR1_ARB_PORT_DMEM : SCR1_ARB_PORT_IMEM;
  endfunction

endpackage

// File: rtl/scr1_mem_arb_id_fifo.sv
// In-order FIFO of issuing port IDs; DEPTH must be a power of two so pointers wrap naturally.
module scr1_arb_id_fifo
  import scr1_mem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  type_scr1_arb_port_e push_id,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output type_scr1_arb_port_e head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]    wptr_q, wptr_d;
  logic [PTR_W-1:0]    rptr_q, rptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  type_scr1_arb_port_e id_q [DEPTH];
  type_scr1_arb_port_e id_d [DEPTH];
  logic                do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = id_q[rptr_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    id_d    = id_q;
    if (do_push) id_d[wptr_q] = push_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read when the count says they are valid.
  always_ff @(posedge clk) begin
    id_q <= id_d;
  end

endmodule

// File: rtl/scr1_mem_arb.sv
// IMEM/DMEM arbiter in front of one memory bridge port, with in-order response steering.
// Define SCR1_ARB_RR_EN for round-robin arbitration; default is fixed DMEM priority.
module scr1_mem_arb
  import scr1_mem_arb_pkg::*;
#(
  parameter int SCR1_ARB_OUTSTD  = 4,
  parameter int SCR1_ADDR_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       imem_req,
  output logic                       imem_req_ack,
  input  logic [SCR1_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_rdata,
  output type_scr1_mem_resp_e        imem_resp,
  input  logic                       dmem_req,
  output logic                       dmem_req_ack,
  input  type_scr1_mem_cmd_e         dmem_cmd,
  input  type_scr1_mem_width_e       dmem_width,
  input  logic [SCR1_ADDR_WIDTH-1:0] dmem_addr,
  input  logic [31:0]                dmem_wdata,
  output logic [31:0]                dmem_rdata,
  output type_scr1_mem_resp_e        dmem_resp,
  output logic                       mem_req,
  output type_scr1_mem_cmd_e         mem_cmd,
  output type_scr1_mem_width_e       mem_width,
  output logic [SCR1_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic                       mem_req_ack,
  input  logic [31:0]                mem_rdata,
  input  type_scr1_mem_resp_e        mem_resp,
  output logic                       arb_idle
);

  logic                lock_q, lock_d;
  type_scr1_arb_port_e lock_port_q, lock_port_d;
  type_scr1_arb_port_e grant;
  logic                granted_req;
  logic                accept;
  logic                resp_vld;
  logic                fifo_full, fifo_empty;
  type_scr1_arb_port_e fifo_head;
`ifdef SCR1_ARB_RR_EN
  type_scr1_arb_port_e last_q, last_d;
`endif

  // State register: grant lock and, in round-robin builds, the last accepted port.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= 1'b0;
      lock_port_q <= SCR1_ARB_PORT_IMEM;
`ifdef SCR1_ARB_RR_EN
      last_q      <= SCR1_ARB_PORT_IMEM;
`endif
    end else begin
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
`ifdef SCR1_ARB_RR_EN
      last_q      <= last_d;
`endif
    end
  end

  // Grant selection and next-state.
  always_comb begin
    grant = SCR1_ARB_PORT_DMEM;
    if (lock_q) begin
      grant = lock_port_q;
    end else if (imem_req & dmem_req) begin
`ifdef SCR1_ARB_RR_EN
      grant = arb_port_other(last_q);
`else
      grant = SCR1_ARB_PORT_DMEM;
`endif
    end else if (imem_req) begin
      grant = SCR1_ARB_PORT_IMEM;
    end
    granted_req = (grant == SCR1_ARB_PORT_DMEM) ? dmem_req : imem_req;
    accept      = mem_req & mem_req_ack;
    // Hold the grant while a request is pending so the bridge never sees the address change.
    lock_d      = granted_req & ~accept;
    lock_port_d = grant;
`ifdef SCR1_ARB_RR_EN
    last_d      = accept ? grant : last_q;
`endif
  end

  // Outputs: request forwarding and response steering.
  always_comb begin
    mem_req      = granted_req & ~fifo_full & ~rst;
    mem_cmd      = SCR1_MEM_CMD_RD;
    mem_width    = SCR1_MEM_WIDTH_WORD;
    mem_addr     = imem_addr;
    mem_wdata    = 32'h0;
    if (grant == SCR1_ARB_PORT_DMEM) begin
      mem_cmd   = dmem_cmd;
      mem_width = dmem_width;
      mem_addr  = dmem_addr;
      mem_wdata = dmem_wdata;
    end
    imem_req_ack = mem_req & mem_req_ack & (grant == SCR1_ARB_PORT_IMEM);
    dmem_req_ack = mem_req & mem_req_ack & (grant == SCR1_ARB_PORT_DMEM);

    resp_vld   = (mem_resp != SCR1_MEM_RESP_NOTRDY) & ~fifo_empty & ~rst;
    imem_resp  = SCR1_MEM_RESP_NOTRDY;
    imem_rdata = 32'h0;
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = 32'h0;
    if (resp_vld) begin
      if (fifo_head == SCR1_ARB_PORT_IMEM) begin
        imem_resp  = mem_resp;
        imem_rdata = mem_rdata;
      end else begin
        dmem_resp  = mem_resp;
        dmem_rdata = mem_rdata;
      end
    end
    arb_idle = fifo_empty;
  end

  scr1_arb_id_fifo #(
    .DEPTH (SCR1_ARB_OUTSTD)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .push_id (grant),
    .pop     (resp_vld),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // A response with nothing outstanding is a bridge protocol error; it is dropped.
  resp_has_owner : assert property (@(posedge clk) disable iff (rst)
    (mem_resp != SCR1_MEM_RESP_NOTRDY) |-> !fifo_empty);

endmodule

// File: tb/tb_scr1_mem_arb.sv
// Bench for scr1_mem_arb: directed cycle table followed by random traffic against a queue model.
module tb_scr1_mem_arb;
  import scr1_mem_arb_pkg::*;

`ifdef SCR1_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam logic [1:0] N  = 2'd0;
  localparam logic [1:0] OK = 2'd1;
  localparam logic [1:0] ER = 2'd2;

  logic clk = 1'b0;
  logic rst;
  logic imem_req, imem_req_ack, dmem_req, dmem_req_ack;
  logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  type_scr1_mem_resp_e  imem_resp, dmem_resp, mem_resp;
  type_scr1_mem_cmd_e   dmem_cmd, mem_cmd;
  type_scr1_mem_width_e dmem_width, mem_width;
  logic mem_req, mem_req_ack, arb_idle;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scr1_mem_arb dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_req_ack(imem_req_ack), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_req_ack(dmem_req_ack), .dmem_cmd(dmem_cmd),
    .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_width(mem_width), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_req_ack(mem_req_ack), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .arb_idle(arb_idle)
  );

  typedef struct {
    logic rst; logic ireq; logic [31:0] iaddr; logic dreq; logic dwr; logic [31:0] daddr;
    logic mack; logic [1:0] resp; logic [31:0] rdata;
    logic e_req; logic [31:0] e_addr; logic e_iack; logic e_dack;
    logic [1:0] e_iresp; logic [1:0] e_dresp; logic e_idle;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                     input logic dw, input logic [31:0] da, input logic ma, input logic [1:0] rs,
                     input logic [31:0] rd, input logic er, input logic [31:0] ea, input logic eia,
                     input logic eda, input logic [1:0] eir, input logic [1:0] edr, input logic ei);
    vec_t v;
    v = '{r, ir, ia, dr, dw, da, ma, rs, rd, er, ea, eia, eda, eir, edr, ei};
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Random-phase reference state: queue of owners, plus grant lock and last accepted port.
  bit q[$];
  bit lock_v, lock_p, last_p;

  initial begin
    rst = 1'b1; imem_req = 0; imem_addr = 0; dmem_req = 0; dmem_addr = 0; dmem_wdata = 0;
    dmem_cmd = SCR1_MEM_CMD_RD; dmem_width = SCR1_MEM_WIDTH_WORD;
    mem_req_ack = 0; mem_rdata = 0; mem_resp = SCR1_MEM_RESP_NOTRDY;

    // IMEM alone
    add(0,1,'h100,0,0,0,1,N,0,          1,'h100,1,0,N,N,1);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,0);
    add(0,0,0,0,0,0,0,OK,'hDEADBEEF,    0,0,0,0,OK,N,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);
    // Both requesting
    add(0,1,'h200,1,0,'h300,1,N,0,      1,'h300,0,1,N,N,1);
    add(0,1,'h200,1,0,'h300,1,N,0,      1,RR ? 32'h200 : 32'h300,RR,!RR,N,N,0);
    add(0,1,'h200,1,0,'h300,1,N,0,      1,'h300,0,1,N,N,0);
    add(0,0,0,0,0,0,0,OK,'h1,           0,0,0,0,N,OK,0);
    add(0,0,0,0,0,0,0,OK,'h2,           0,0,0,0,RR ? OK : N,RR ? N : OK,0);
    add(0,0,0,0,0,0,0,OK,'h3,           0,0,0,0,N,OK,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);
    // Grant lock while bridge stalls
    add(0,1,'h400,0,0,0,0,N,0,          1,'h400,0,0,N,N,1);
    add(0,1,'h400,1,0,'h500,0,N,0,      1,'h400,0,0,N,N,1);
    add(0,1,'h400,1,0,'h500,0,N,0,      1,'h400,0,0,N,N,1);
    add(0,1,'h400,1,0,'h500,1,N,0,      1,'h400,1,0,N,N,1);
    add(0,1,'h404,1,0,'h500,1,N,0,      1,'h500,0,1,N,N,0);
    add(0,0,0,0,0,0,0,OK,'h11,          0,0,0,0,OK,N,0);
    add(0,0,0,0,0,0,0,OK,'h22,          0,0,0,0,N,OK,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);
    // Fill to capacity, full blocks even with a same-cycle pop
    for (int k = 0; k < 4; k++)
      add(0,0,0,1,1,32'h600 + 32'(4*k),1,N,0, 1,32'h600 + 32'(4*k),0,1,N,N,k == 0);
    add(0,0,0,1,1,'h610,1,OK,'h33,      0,0,0,0,N,OK,0);
    add(0,0,0,1,1,'h610,1,N,0,          1,'h610,0,1,N,N,0);
    for (int k = 0; k < 4; k++)
      add(0,0,0,0,0,0,0,OK,32'h40 + 32'(k), 0,0,0,0,N,OK,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);
    // Interleaved D-WR, I-RD, D-RD with ER, OK, OK
    add(0,0,0,1,1,'h700,1,N,0,          1,'h700,0,1,N,N,1);
    add(0,1,'h104,0,0,0,1,N,0,          1,'h104,1,0,N,N,0);
    add(0,0,0,1,0,'h704,1,N,0,          1,'h704,0,1,N,N,0);
    add(0,0,0,0,0,0,0,ER,'hBAD,         0,0,0,0,N,ER,0);
    add(0,0,0,0,0,0,0,OK,'h44,          0,0,0,0,OK,N,0);
    add(0,0,0,0,0,0,0,OK,'h55,          0,0,0,0,N,OK,0);
    // Reset with two outstanding
    add(0,1,'h108,0,0,0,1,N,0,          1,'h108,1,0,N,N,1);
    add(0,0,0,1,0,'h708,1,N,0,          1,'h708,0,1,N,N,0);
    add(1,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);
    add(0,1,'h10C,0,0,0,1,N,0,          1,'h10C,1,0,N,N,1);
    add(0,0,0,0,0,0,0,OK,'h66,          0,0,0,0,OK,N,0);
    add(0,0,0,0,0,0,0,N,0,              0,0,0,0,N,N,1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vq[i]) begin
      vec_t v;
      v = vq[i];
      @(posedge clk);
      #1;
      rst = v.rst; imem_req = v.ireq; imem_addr = v.iaddr;
      dmem_req = v.dreq; dmem_addr = v.daddr; dmem_wdata = v.daddr ^ 32'h5A5A0000;
      dmem_cmd = v.dwr ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
      dmem_width = SCR1_MEM_WIDTH_WORD;
      mem_req_ack = v.mack; mem_resp = type_scr1_mem_resp_e'(v.resp); mem_rdata = v.rdata;
      @(negedge clk);
      chk($sformatf("row%0d mem_req", i), 32'(mem_req), 32'(v.e_req));
      if (v.e_req) chk($sformatf("row%0d mem_addr", i), mem_addr, v.e_addr);
      chk($sformatf("row%0d imem_ack", i), 32'(imem_req_ack), 32'(v.e_iack));
      chk($sformatf("row%0d dmem_ack", i), 32'(dmem_req_ack), 32'(v.e_dack));
      chk($sformatf("row%0d imem_resp", i), 32'(imem_resp), 32'(v.e_iresp));
      chk($sformatf("row%0d imem_rdata", i), imem_rdata, (v.e_iresp != N) ? v.rdata : 32'h0);
      chk($sformatf("row%0d dmem_resp", i), 32'(dmem_resp), 32'(v.e_dresp));
      chk($sformatf("row%0d dmem_rdata", i), dmem_rdata, (v.e_dresp != N) ? v.rdata : 32'h0);
      chk($sformatf("row%0d arb_idle", i), 32'(arb_idle), 32'(v.e_idle));
    end

    // Random traffic
    @(posedge clk);
    #1 rst = 1'b1; imem_req = 0; dmem_req = 0; mem_resp = SCR1_MEM_RESP_NOTRDY;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete(); lock_v = 0; lock_p = 0; last_p = 0;
    for (int c = 0; c < 3000; c++) begin
      bit g, greq, ereq, acc;
      logic [1:0] rs;
      logic [1:0] exp_ir, exp_dr;
      if (c != 0) @(posedge clk);
      #1;
      imem_req = 1'($urandom_range(0, 1));
      dmem_req = 1'($urandom_range(0, 1));
      imem_addr = $urandom; dmem_addr = $urandom; dmem_wdata = $urandom; mem_rdata = $urandom;
      dmem_cmd = type_scr1_mem_cmd_e'($urandom_range(0, 1));
      dmem_width = type_scr1_mem_width_e'($urandom_range(0, 2));
      mem_req_ack = ($urandom_range(0, 2) != 0);
      rs = (q.size() > 0 && $urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 2)) : N;
      mem_resp = type_scr1_mem_resp_e'(rs);

      if (lock_v) g = lock_p;
      else if (imem_req && dmem_req) g = RR ? !last_p : 1'b1;
      else g = !imem_req;
      greq = g ? dmem_req : imem_req;
      ereq = greq && (q.size() < 4);
      acc  = ereq && mem_req_ack;
      exp_ir = (rs != N && q[0] == 1'b0) ? rs : N;
      exp_dr = (rs != N && q[0] == 1'b1) ? rs : N;

      @(negedge clk);
      chk($sformatf("rnd%0d mem_req", c), 32'(mem_req), 32'(ereq));
      if (ereq) begin
        chk($sformatf("rnd%0d mem_addr", c), mem_addr, g ? dmem_addr : imem_addr);
        chk($sformatf("rnd%0d mem_cmd", c), 32'(mem_cmd), g ? 32'(dmem_cmd) : 32'(SCR1_MEM_CMD_RD));
        chk($sformatf("rnd%0d mem_width", c), 32'(mem_width),
            g ? 32'(dmem_width) : 32'(SCR1_MEM_WIDTH_WORD));
        if (g) chk($sformatf("rnd%0d mem_wdata", c), mem_wdata, dmem_wdata);
      end
      chk($sformatf("rnd%0d imem_ack", c), 32'(imem_req_ack), 32'(acc && !g));
      chk($sformatf("rnd%0d dmem_ack", c), 32'(dmem_req_ack), 32'(acc && g));
      chk($sformatf("rnd%0d imem_resp", c), 32'(imem_resp), 32'(exp_ir));
      chk($sformatf("rnd%0d imem_rdata", c), imem_rdata, (exp_ir != N) ? mem_rdata : 32'h0);
      chk($sformatf("rnd%0d dmem_resp", c), 32'(dmem_resp), 32'(exp_dr));
      chk($sformatf("rnd%0d dmem_rdata", c), dmem_rdata, (exp_dr != N) ? mem_rdata : 32'h0);
      chk($sformatf("rnd%0d arb_idle", c), 32'(arb_idle), 32'(q.size() == 0));

      if (rs != N) void'(q.pop_front());
      if (acc) begin
        q.push_back(g);
        last_p = g;
      end
      lock_v = greq && !acc;
      lock_p = g;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
